// File: rtl/prach_fft_pkg.sv
// Shared types and constant helpers for the PRACH long-sequence radix-3 FFT stages.
// The localparams give the default 2187-point, stage-0 configuration.
package prach_fft_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    function automatic int pow3(input int e);
        int r;
        r = 1;
        for (int i = 0; i < e; i++) r = r * 3;
        return r;
    endfunction

    localparam int LOG3N_DEF = 7;
    localparam int STAGE_DEF = 0;
    localparam int N         = pow3(LOG3N_DEF);
    localparam int TW_STEP   = pow3(LOG3N_DEF - 1 - STAGE_DEF);

endpackage

// File: rtl/prach_tw_acc.sv
// Modulo-N step accumulator used to build twiddle indices without a multiplier.
// Clear has priority over enable; the wrap is a single conditional subtract.
module prach_tw_acc #(
    parameter int N    = 2187,
    parameter int STEP = 1,
    parameter int AW   = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    output logic [AW-1:0] acc
);

    logic [AW:0] sum;

    assign sum = {1'b0, acc} + (AW+1)'(STEP);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            acc <= '0;
        end else if (en) begin
            if (sum >= (AW+1)'(N)) acc <= AW'(sum - (AW+1)'(N));
            else                   acc <= sum[AW-1:0];
        end
    end

endmodule

// File: rtl/prach_ditfft3_ctrl.sv
// Radix-3 DIT stage sequencer: frames samples into triplets, drives butterfly sync/valid and twiddle index.
// Optional PRACH_DITFFT3_CTRL_WDOG_EN adds a 16-bit stall watchdog that aborts a frame stuck in RUN.
module prach_ditfft3_ctrl
    import prach_fft_pkg::*;
#(
    parameter int LOG3N    = 7,
    parameter int STAGE    = 0,
    parameter int PIPE_LAT = 2,
    parameter int TW_AW    = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             frame_start,
    input  logic             din_dv,
    output logic             bf_sync,
    output logic             bf_dv,
    output logic [TW_AW-1:0] tw_addr,
    output logic             tw_valid,
    output logic             busy,
    output logic             frame_done,
    output logic             frame_err,
    output logic [1:0]       dbg_state
);

    localparam int FRAME_N = pow3(LOG3N);
    localparam int SPAN_L  = pow3(STAGE);
    localparam int STEP    = pow3(LOG3N - 1 - STAGE);
    localparam int STEP2   = (2 * STEP) % FRAME_N;
    localparam int JW      = (SPAN_L > 1) ? $clog2(SPAN_L) : 1;
    localparam int SW      = $clog2(FRAME_N);
    localparam int DW      = $clog2(PIPE_LAT + 2);
    localparam logic [JW-1:0] J_LAST = JW'(SPAN_L - 1);
    localparam logic [SW-1:0] S_LAST = SW'(FRAME_N - 1);
    localparam logic [DW-1:0] D_LOAD = DW'(PIPE_LAT + 1);

    state_e           state;
    logic [1:0]       m;
    logic [JW-1:0]    j;
    logic [SW-1:0]    s;
    logic [DW-1:0]    drain_cnt;
    logic [TW_AW-1:0] acc1, acc2, tw_sel;
    logic             start_ok, run_acc, triplet_end, span_end;
`ifdef PRACH_DITFFT3_CTRL_WDOG_EN
    logic [15:0]      wdog;
`endif

    // A start during DRAIN is dropped; otherwise it always makes this sample x0.
    assign start_ok    = frame_start & din_dv & (state != DRAIN);
    assign run_acc     = (state == RUN) & din_dv & ~frame_start;
    assign triplet_end = run_acc & (m == 2'd2);
    assign span_end    = triplet_end & (j == J_LAST);
    assign busy        = (state != IDLE);
    assign dbg_state   = state;

    always_comb begin
        tw_sel = '0;
        if (!start_ok) begin
            if (m == 2'd1)      tw_sel = acc1;
            else if (m == 2'd2) tw_sel = acc2;
        end
    end

    prach_tw_acc #(.N(FRAME_N), .STEP(STEP), .AW(TW_AW)) u_acc1 (
        .clk(clk), .rst(rst), .clr(start_ok | span_end), .en(triplet_end), .acc(acc1)
    );

    prach_tw_acc #(.N(FRAME_N), .STEP(STEP2), .AW(TW_AW)) u_acc2 (
        .clk(clk), .rst(rst), .clr(start_ok | span_end), .en(triplet_end), .acc(acc2)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            m          <= '0;
            j          <= '0;
            s          <= '0;
            drain_cnt  <= '0;
            bf_sync    <= 1'b0;
            bf_dv      <= 1'b0;
            tw_addr    <= '0;
            tw_valid   <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
`ifdef PRACH_DITFFT3_CTRL_WDOG_EN
            wdog       <= '0;
`endif
        end else begin
            bf_sync    <= 1'b0;
            bf_dv      <= 1'b0;
            tw_addr    <= '0;
            tw_valid   <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= frame_start & (~din_dv | (state != IDLE));
            if (start_ok || run_acc) begin
                bf_dv    <= 1'b1;
                tw_valid <= 1'b1;
                bf_sync  <= start_ok | (m == 2'd0);
                tw_addr  <= tw_sel;
            end
            case (state)
                IDLE: begin
`ifdef PRACH_DITFFT3_CTRL_WDOG_EN
                    wdog <= '0;
`endif
                    if (start_ok) begin
                        state <= RUN;
                        m     <= 2'd1;
                        j     <= '0;
                        s     <= SW'(1);
                    end
                end
                RUN: begin
                    if (start_ok) begin
                        m <= 2'd1;
                        j <= '0;
                        s <= SW'(1);
`ifdef PRACH_DITFFT3_CTRL_WDOG_EN
                        wdog <= '0;
`endif
                    end else if (run_acc) begin
`ifdef PRACH_DITFFT3_CTRL_WDOG_EN
                        wdog <= '0;
`endif
                        if (s == S_LAST) begin
                            state     <= DRAIN;
                            drain_cnt <= D_LOAD;
                            m         <= '0;
                            j         <= '0;
                            s         <= '0;
                        end else begin
                            s <= s + SW'(1);
                            m <= (m == 2'd2) ? 2'd0 : m + 2'd1;
                            if (m == 2'd2) j <= (j == J_LAST) ? '0 : j + JW'(1);
                        end
                    end else begin
`ifdef PRACH_DITFFT3_CTRL_WDOG_EN
                        // 0xFFFE stalls already counted: this is the 65535th.
                        if (!din_dv && wdog == 16'hFFFE) begin
                            frame_err <= 1'b1;
                            state     <= IDLE;
                            m         <= '0;
                            j         <= '0;
                            s         <= '0;
                            wdog      <= '0;
                        end else if (!din_dv) begin
                            wdog <= wdog + 16'd1;
                        end
`endif
                    end
                end
                DRAIN: begin
`ifdef PRACH_DITFFT3_CTRL_WDOG_EN
                    wdog <= '0;
`endif
                    if (drain_cnt == '0) begin
                        frame_done <= 1'b1;
                        state      <= IDLE;
                    end else begin
                        drain_cnt <= drain_cnt - DW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_prach_ditfft3_ctrl.sv
// Bench for prach_ditfft3_ctrl at LOG3N=3, STAGE=1: a 27-sample frame with 3-wide spans.
// Reference model derives each sample's triplet position, span index and twiddle from its frame index.
module tb_prach_ditfft3_ctrl;

    localparam int LOG3N    = 3;
    localparam int STAGE    = 1;
    localparam int PIPE_LAT = 2;
    localparam int TW_AW    = 5;
    localparam int N        = 3 ** LOG3N;
    localparam int L        = 3 ** STAGE;
    localparam int STEP     = 3 ** (LOG3N - 1 - STAGE);
    localparam int W        = 1 + TW_AW;
`ifdef PRACH_DITFFT3_CTRL_WDOG_EN
    localparam int STALL    = 65540;
`else
    localparam int STALL    = 300;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             frame_start = 1'b0;
    logic             din_dv = 1'b0;
    logic             bf_sync, bf_dv, tw_valid, busy, frame_done, frame_err;
    logic [TW_AW-1:0] tw_addr;
    logic [1:0]       dbg_state;

    prach_ditfft3_ctrl #(
        .LOG3N(LOG3N), .STAGE(STAGE), .PIPE_LAT(PIPE_LAT), .TW_AW(TW_AW)
    ) dut (
        .clk(clk), .rst(rst), .frame_start(frame_start), .din_dv(din_dv),
        .bf_sync(bf_sync), .bf_dv(bf_dv), .tw_addr(tw_addr), .tw_valid(tw_valid),
        .busy(busy), .frame_done(frame_done), .frame_err(frame_err), .dbg_state(dbg_state)
    );

    // clock / cycle counter (cyc equals the index of the most recent rising edge)
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    // scoreboard state
    logic [W-1:0] exp_q[$];
    int           exp_cyc_q[$];
    int           done_q[$];
    int           err_q[$];
    bit           in_frame = 1'b0;
    bit           exp_busy = 1'b0;
    bit           mon_en = 1'b0;
    int           k = 0;
    int           drain_end = -100;
    int           gap = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected butterfly output for frame sample k, captured at edge e.
    task automatic emit(input int e);
        int m;
        int j;
        logic sy;
        logic [TW_AW-1:0] tw;
        m  = k % 3;
        j  = (k / 3) % L;
        sy = (m == 0);
        tw = TW_AW'((m * j * STEP) % N);
        exp_q.push_back({sy, tw});
        exp_cyc_q.push_back(e);
        if (k == N - 1) begin
            in_frame  = 1'b0;
            drain_end = e + PIPE_LAT + 2;
            done_q.push_back(drain_end);
        end
        k++;
    endtask

    task automatic model_step(input logic fs, input logic dv);
        int e;
        bit draining;
        e = cyc;
        draining = (e <= drain_end);
        if (fs && (!dv || in_frame || draining)) err_q.push_back(e);
        if (draining) begin
        end else if (fs && dv) begin
            in_frame = 1'b1;
            k = 0;
            gap = 0;
            emit(e);
        end else if (in_frame && dv) begin
            gap = 0;
            emit(e);
        end else if (in_frame) begin
`ifdef PRACH_DITFFT3_CTRL_WDOG_EN
            gap++;
            if (gap == 65535) begin
                err_q.push_back(e);
                in_frame = 1'b0;
                gap = 0;
            end
`endif
        end
        exp_busy = in_frame || (e < drain_end);
    endtask

    task automatic model_reset();
        in_frame  = 1'b0;
        drain_end = -100;
        gap       = 0;
        exp_busy  = 1'b0;
    endtask

    // driver
    task automatic drive(input logic fs, input logic dv);
        frame_start = fs;
        din_dv      = dv;
        @(posedge clk);
        #1;
        model_step(fs, dv);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0);
    endtask

    task automatic check_quiet(input string tag);
        chk({tag, "_bf_dv"}, bf_dv, 0);
        chk({tag, "_bf_sync"}, bf_sync, 0);
        chk({tag, "_tw_addr"}, tw_addr, 0);
        chk({tag, "_tw_valid"}, tw_valid, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_frame_done"}, frame_done, 0);
        chk({tag, "_frame_err"}, frame_err, 0);
    endtask

    // monitor
    always @(negedge clk) begin
        logic [W-1:0] e;
        int ec;
        if (mon_en) begin
            chk("tw_valid", tw_valid, bf_dv);
            chk("busy", busy, exp_busy);
            if (bf_dv) begin
                if (exp_q.size() == 0) begin
                    chk("bf_dv_unexpected", 1, 0);
                end else begin
                    e  = exp_q.pop_front();
                    ec = exp_cyc_q.pop_front();
                    chk("bf_cycle", cyc, ec);
                    chk("bf_sync", bf_sync, e[W-1]);
                    chk("tw_addr", tw_addr, e[TW_AW-1:0]);
                end
            end else begin
                chk("bf_sync_idle", bf_sync, 0);
            end
            if (frame_done) begin
                if (done_q.size() == 0) chk("frame_done_unexpected", 1, 0);
                else chk("frame_done_cycle", cyc, done_q.pop_front());
            end
            if (frame_err) begin
                if (err_q.size() == 0) chk("frame_err_unexpected", 1, 0);
                else chk("frame_err_cycle", cyc, err_q.pop_front());
            end
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_quiet("reset");
        chk("reset_state", dbg_state, 0);
        rst = 1'b0;
        mon_en = 1'b1;

        // contiguous frame
        drive(1'b1, 1'b1);
        for (int i = 1; i < N; i++) drive(1'b0, 1'b1);
        idle(8);

        // five-cycle gap after sample 4
        drive(1'b1, 1'b1);
        for (int i = 1; i < 5; i++) drive(1'b0, 1'b1);
        idle(5);
        for (int i = 5; i < N; i++) drive(1'b0, 1'b1);
        idle(8);

        // restart at sample 5, then a full frame
        drive(1'b1, 1'b1);
        for (int i = 1; i < 5; i++) drive(1'b0, 1'b1);
        drive(1'b1, 1'b1);
        for (int i = 1; i < N; i++) drive(1'b0, 1'b1);
        idle(8);

        // start during drain is dropped, later samples in IDLE are ignored
        drive(1'b1, 1'b1);
        for (int i = 1; i < N; i++) drive(1'b0, 1'b1);
        drive(1'b0, 1'b0);
        drive(1'b1, 1'b1);
        drive(1'b0, 1'b1);
        idle(6);
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b1);
        drive(1'b1, 1'b0);
        idle(3);

        // reset in the middle of a frame
        drive(1'b1, 1'b1);
        for (int i = 1; i < 4; i++) drive(1'b0, 1'b1);
        rst = 1'b1;
        frame_start = 1'b0;
        din_dv = 1'b1;
        @(posedge clk);
        #1;
        model_reset();
        check_quiet("midrst");
        rst = 1'b0;
        idle(8);

        // long stall inside RUN
        drive(1'b1, 1'b1);
        drive(1'b0, 1'b1);
        drive(1'b0, 1'b1);
        idle(STALL);
        for (int i = 3; i < N; i++) drive(1'b0, 1'b1);
        idle(8);

        // randomized frames with gaps and stray starts
        for (int f = 0; f < 10; f++) begin
            drive(1'b1, 1'b1);
            repeat ($urandom_range(30, 60))
                drive(($urandom_range(0, 40) == 0), ($urandom_range(0, 3) != 0));
            idle($urandom_range(0, 6));
        end

        idle(PIPE_LAT + 8);
        chk("exp_q_left", exp_q.size(), 0);
        chk("done_q_left", done_q.size(), 0);
        chk("err_q_left", err_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
